// File: rtl/bram_run_scheduler.sv
// bram_run_scheduler: queues {count, base} run jobs and launches them one at a
// time on the BRAM accessor, waiting for each done before the next start.
module bram_run_scheduler #(
  parameter int unsigned CNT_BIT = 31,
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned QAW     = 2,
  parameter int unsigned DONE_CW = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic [CNT_BIT-1:0] push_count_i,
  input  logic [AWIDTH-1:0]  push_base_i,
  input  logic               flush_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [QAW:0]       level_o,
  input  logic               acc_idle_i,
  input  logic               acc_done_i,
  output logic               acc_start_o,
  output logic [CNT_BIT-1:0] acc_count_o,
  output logic [AWIDTH-1:0]  acc_base_o,
  output logic               busy_o,
  output logic               job_done_o,
  output logic [DONE_CW-1:0] done_cnt_o,
  output logic               err_ovf_o,
  output logic               err_zero_o
);

  localparam int unsigned LW = QAW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_BIT-1:0] q_count_q [QDEPTH];
  logic [AWIDTH-1:0]  q_base_q  [QDEPTH];

  logic [QAW-1:0]     wptr_q, wptr_d;
  logic [QAW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_zero_q, err_zero_d;

  logic               acc_start_q, acc_start_d;
  logic [CNT_BIT-1:0] acc_count_q, acc_count_d;
  logic [AWIDTH-1:0]  acc_base_q, acc_base_d;
  logic               busy_q, busy_d;
  logic               job_done_q, job_done_d;
  logic [DONE_CW-1:0] done_cnt_q, done_cnt_d;

  logic               pop;
  logic               push_ok;
  logic               push_zero;
  logic               push_ovf;

  // Push qualification: flush silently wins over every other push outcome.
  always_comb begin
    push_zero = push_i && !flush_i && (push_count_i == '0);
    push_ovf  = push_i && !flush_i && full_q;
    push_ok   = push_i && !flush_i && !full_q && (push_count_i != '0);
  end

  // Scheduler next-state: pop only from IDLE when a job waits and the accessor is idle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q && acc_idle_i && !flush_i) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (acc_done_i) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Queue bookkeeping, sticky errors and registered accessor-side outputs.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    err_ovf_d  = err_ovf_q;
    err_zero_d = err_zero_q;
    done_cnt_d = done_cnt_q;

    if (flush_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      err_ovf_d  = 1'b0;
      err_zero_d = 1'b0;
    end else begin
      wptr_d  = wptr_q + QAW'(push_ok);
      rptr_d  = rptr_q + QAW'(pop);
      level_d = level_q + LW'(push_ok) - LW'(pop);
      if (push_ovf)  err_ovf_d  = 1'b1;
      if (push_zero) err_zero_d = 1'b1;
    end

    full_d  = (level_d == LW'(QDEPTH));
    empty_d = (level_d == '0);

    if (state_q == S_WAIT && acc_done_i) done_cnt_d = done_cnt_q + DONE_CW'(1);

    acc_start_d = pop;
    acc_count_d = pop ? q_count_q[rptr_q] : '0;
    if (pop) begin
      acc_base_d = q_base_q[rptr_q];
    end else if (state_d == S_IDLE) begin
      acc_base_d = '0;
    end else begin
      acc_base_d = acc_base_q;
    end
    busy_d     = (state_d != S_IDLE);
    job_done_d = (state_d == S_DONE);
  end

  // Job storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_count_q[wptr_q] <= push_count_i;
      q_base_q[wptr_q]  <= push_base_i;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_ovf_q   <= 1'b0;
      err_zero_q  <= 1'b0;
      acc_start_q <= 1'b0;
      acc_count_q <= '0;
      acc_base_q  <= '0;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_ovf_q   <= err_ovf_d;
      err_zero_q  <= err_zero_d;
      acc_start_q <= acc_start_d;
      acc_count_q <= acc_count_d;
      acc_base_q  <= acc_base_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign level_o     = level_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_zero_o  = err_zero_q;
  assign acc_start_o = acc_start_q;
  assign acc_count_o = acc_count_q;
  assign acc_base_o  = acc_base_q;
  assign busy_o      = busy_q;
  assign job_done_o  = job_done_q;
  assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_bram_run_scheduler.sv
// Bench for bram_run_scheduler: directed scenarios plus random traffic, an
// emulated accessor, a job-queue reference model and a decoupled monitor.
module tb_bram_run_scheduler;

  localparam int unsigned CNT_BIT = 31;
  localparam int unsigned AWIDTH  = 8;
  localparam int unsigned QDEPTH  = 4;
  localparam int unsigned QAW     = 2;
  localparam int unsigned DONE_CW = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               push_i;
  logic [CNT_BIT-1:0] push_count_i;
  logic [AWIDTH-1:0]  push_base_i;
  logic               flush_i;
  logic               full_o, empty_o;
  logic [QAW:0]       level_o;
  logic               acc_idle_i, acc_done_i;
  logic               acc_start_o;
  logic [CNT_BIT-1:0] acc_count_o;
  logic [AWIDTH-1:0]  acc_base_o;
  logic               busy_o, job_done_o;
  logic [DONE_CW-1:0] done_cnt_o;
  logic               err_ovf_o, err_zero_o;

  // Emulated accessor and directed overrides
  logic acc_idle_int, acc_done_int;
  logic hold_nonidle, spur_done;
  int   acc_lat;
  int   acc_cnt;
  bit   acc_active;
  assign acc_idle_i = acc_idle_int & ~hold_nonidle;
  assign acc_done_i = acc_done_int | spur_done;

  always #5 clk = ~clk;

  bram_run_scheduler #(
    .CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH), .QDEPTH(QDEPTH), .QAW(QAW), .DONE_CW(DONE_CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .push_i(push_i), .push_count_i(push_count_i), .push_base_i(push_base_i),
    .flush_i(flush_i), .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .acc_idle_i(acc_idle_i), .acc_done_i(acc_done_i),
    .acc_start_o(acc_start_o), .acc_count_o(acc_count_o), .acc_base_o(acc_base_o),
    .busy_o(busy_o), .job_done_o(job_done_o), .done_cnt_o(done_cnt_o),
    .err_ovf_o(err_ovf_o), .err_zero_o(err_zero_o)
  );

  typedef struct {
    logic [CNT_BIT-1:0] cnt;
    logic [AWIDTH-1:0]  base;
  } job_t;

  // Reference model state (written at posedge by the model only)
  job_t exp_jobs[$];
  int   wr_idx = 0;
  int   fb_idx = 0;
  bit   last_idle = 1'b0, last_flush = 1'b0, done_at_edge = 1'b0;
  bit   m_ovf = 1'b0, m_zero = 1'b0;

  // Monitor state (written at negedge by the monitor only)
  int               rd_idx = 0;
  int               phase = 0;
  bit               stall = 1'b0;
  logic [AWIDTH-1:0] cur_base = '0;
  int               exp_cnt = 0;
  int               n_checks = 0;
  int               n_errors = 0;

  function automatic int eff_rd();
    return (rd_idx > fb_idx) ? rd_idx : fb_idx;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Accessor emulation: goes busy on start, returns done after acc_lat cycles.
  initial begin
    acc_idle_int = 1'b1;
    acc_done_int = 1'b0;
    acc_active   = 1'b0;
    acc_cnt      = 0;
    forever begin
      @(negedge clk);
      acc_done_int = 1'b0;
      if (!reset_n) begin
        acc_active   = 1'b0;
        acc_idle_int = 1'b1;
      end else if (acc_active) begin
        if (acc_cnt == 0) begin
          acc_done_int = 1'b1;
          acc_idle_int = 1'b1;
          acc_active   = 1'b0;
        end else begin
          acc_cnt--;
        end
      end else if (acc_start_o) begin
        acc_active   = 1'b1;
        acc_idle_int = 1'b0;
        acc_cnt      = (acc_lat < 0) ? int'($urandom_range(0, 6)) : acc_lat;
      end
    end
  end

  // Reference model: job queue with drop rules and sticky errors, sampled each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        fb_idx       = wr_idx;
        m_ovf        = 1'b0;
        m_zero       = 1'b0;
        done_at_edge = 1'b0;
        last_idle    = 1'b0;
        last_flush   = 1'b0;
      end else begin
        int pre_size;
        job_t j;
        pre_size     = wr_idx - eff_rd();
        last_idle    = acc_idle_i;
        last_flush   = flush_i;
        done_at_edge = acc_done_i;
        if (flush_i) begin
          fb_idx = wr_idx;
          m_ovf  = 1'b0;
          m_zero = 1'b0;
        end else if (push_i) begin
          if (pre_size == int'(QDEPTH)) m_ovf = 1'b1;
          if (push_count_i == '0) m_zero = 1'b1;
          if (pre_size < int'(QDEPTH) && push_count_i != '0) begin
            j.cnt  = push_count_i;
            j.base = push_base_i;
            exp_jobs.push_back(j);
            wr_idx++;
          end
        end
      end
    end
  end

  // Monitor: compares every output each cycle against the model and job lifecycle.
  initial begin
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        #1;
        phase   = 0;
        stall   = 1'b0;
        exp_cnt = 0;
        chk("rst_acc_start", 64'(acc_start_o), 64'(0));
        chk("rst_acc_count", 64'(acc_count_o), 64'(0));
        chk("rst_acc_base",  64'(acc_base_o),  64'(0));
        chk("rst_busy",      64'(busy_o),      64'(0));
        chk("rst_job_done",  64'(job_done_o),  64'(0));
        chk("rst_done_cnt",  64'(done_cnt_o),  64'(0));
        chk("rst_err_ovf",   64'(err_ovf_o),   64'(0));
        chk("rst_err_zero",  64'(err_zero_o),  64'(0));
        chk("rst_level",     64'(level_o),     64'(0));
        chk("rst_empty",     64'(empty_o),     64'(1));
        chk("rst_full",      64'(full_o),      64'(0));
      end else begin
        bit launch_ok;
        int lvl;
        launch_ok = stall && last_idle && !last_flush;
        if (phase == 3) phase = 0;
        else if (phase == 1) phase = 2;
        else if (phase == 2 && done_at_edge) begin
          phase   = 3;
          exp_cnt = (exp_cnt + 1) % (1 << DONE_CW);
        end
        chk("acc_start", 64'(acc_start_o), 64'(launch_ok));
        if (acc_start_o) begin
          if (rd_idx < fb_idx) rd_idx = fb_idx;
          chk("launch_has_job", 64'(rd_idx < exp_jobs.size()), 64'(1));
          if (rd_idx < exp_jobs.size()) begin
            chk("launch_count", 64'(acc_count_o), 64'(exp_jobs[rd_idx].cnt));
            chk("launch_base",  64'(acc_base_o),  64'(exp_jobs[rd_idx].base));
            cur_base = exp_jobs[rd_idx].base;
            rd_idx++;
          end
          phase = 1;
        end else begin
          chk("acc_count_idle", 64'(acc_count_o), 64'(0));
        end
        lvl = wr_idx - eff_rd();
        chk("job_done", 64'(job_done_o), 64'(phase == 3));
        chk("busy",     64'(busy_o),     64'(phase != 0));
        chk("acc_base", 64'(acc_base_o), (phase != 0) ? 64'(cur_base) : 64'(0));
        chk("level",    64'(level_o),    64'(lvl));
        chk("full",     64'(full_o),     64'(lvl == int'(QDEPTH)));
        chk("empty",    64'(empty_o),    64'(lvl == 0));
        chk("err_ovf",  64'(err_ovf_o),  64'(m_ovf));
        chk("err_zero", 64'(err_zero_o), 64'(m_zero));
        chk("done_cnt", 64'(done_cnt_o), 64'(exp_cnt));
        stall = (phase == 0) && (lvl > 0);
      end
    end
  end

  task automatic push_job(input int unsigned c, input int unsigned b);
    push_i       = 1'b1;
    push_count_i = CNT_BIT'(c);
    push_base_i  = AWIDTH'(b);
    @(negedge clk);
    push_i = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (!(empty_o && !busy_o && acc_idle_i)) begin
      @(negedge clk);
      n++;
      if (n > maxc) begin
        $display("FAIL drain_timeout: queue/job still active after %0d cycles at %0t", n, $time);
        $fatal(1, "drain bound expired");
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_in_wait(input int maxc);
    int n;
    n = 0;
    while (!(busy_o && !acc_start_o && !job_done_o)) begin
      @(negedge clk);
      n++;
      if (n > maxc) begin
        $display("FAIL wait_state_timeout: no job reached WAIT after %0d cycles at %0t", n, $time);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    push_i  = 1'b0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    reset_n      = 1'b0;
    push_i       = 1'b0;
    push_count_i = '0;
    push_base_i  = '0;
    flush_i      = 1'b0;
    hold_nonidle = 1'b0;
    spur_done    = 1'b0;
    acc_lat      = 5;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single job
    push_job(4, 'h10);
    wait_drain(50);

    // Queue fill with accessor held busy, fifth push overflows
    hold_nonidle = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_job(100 + i, 'h20 + i);
    hold_nonidle = 1'b0;
    acc_lat = 2;
    wait_drain(100);

    // Zero-count push, then flush while a job is in WAIT
    push_job(0, 'h33);
    @(negedge clk);
    acc_lat = 8;
    for (int i = 0; i < 3; i++) push_job(200 + i, 'h40 + i);
    wait_in_wait(20);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    wait_drain(50);

    // Push on the same edge as the IDLE pop, with two queued
    acc_lat = 2;
    hold_nonidle = 1'b1;
    push_job(300, 'h50);
    push_job(301, 'h51);
    hold_nonidle = 1'b0;
    push_job(302, 'h52);
    wait_drain(100);

    // Push on the pop edge while full: dropped
    hold_nonidle = 1'b1;
    for (int i = 0; i < 4; i++) push_job(400 + i, 'h60 + i);
    hold_nonidle = 1'b0;
    push_job(404, 'h64);
    wait_drain(100);

    // Spurious done while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a job is in WAIT, then a normal job
    acc_lat = 10;
    push_job(500, 'h70);
    wait_in_wait(20);
    repeat (2) @(negedge clk);
    do_reset();
    acc_lat = 3;
    push_job(501, 'h71);
    wait_drain(50);

    // Counter wrap: 2^DONE_CW + 1 jobs from a fresh reset
    do_reset();
    acc_lat = -1;
    begin
      int pushed;
      int guard;
      pushed = 0;
      guard  = 0;
      while (pushed < (1 << DONE_CW) + 1 && guard < 2000) begin
        if (!full_o) begin
          push_job(600 + pushed, $urandom);
          pushed++;
        end else begin
          @(negedge clk);
        end
        guard++;
      end
    end
    wait_drain(200);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      flush_i      = ($urandom_range(0, 19) == 0);
      hold_nonidle = ($urandom_range(0, 9) == 0);
      push_i       = ($urandom_range(0, 1) == 1);
      push_count_i = ($urandom_range(0, 7) == 0) ? '0 : CNT_BIT'($urandom_range(1, 100000));
      push_base_i  = AWIDTH'($urandom);
      @(negedge clk);
    end
    push_i       = 1'b0;
    flush_i      = 1'b0;
    hold_nonidle = 1'b0;
    wait_drain(200);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_run_scheduler.md
# bram_run_scheduler

Job scheduler that sequences the BRAM accessor. Host-side logic pushes run jobs (row count plus BRAM base offset) into a small FIFO. The scheduler issues one start pulse per job to the accessor and waits for the accessor's done before launching the next job. It reports completions, queue status and sticky errors, so multiple BRAM0→BRAM1 passes can be queued back-to-back without host polling.

## Interface
- CNT_BIT, 31, width of the run count (matches accessor run_count_i)
- AWIDTH, 8, BRAM address width; width of the base offset
- QDEPTH, 4, job FIFO depth (power of two)
- QAW, 2, log2(QDEPTH)
- DONE_CW, 16, width of the completed-job counter
- clk  in  1  single clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- push_i  in  1  enqueue one job this cycle
- push_count_i  in  CNT_BIT  rows to process for the pushed job
- push_base_i  in  AWIDTH  base address offset for the pushed job
- flush_i  in  1  discard all queued (not in-flight) jobs; clear sticky errors
- full_o  out  1  FIFO holds QDEPTH jobs
- empty_o  out  1  FIFO holds 0 jobs
- level_o  out  QAW+1  number of queued jobs
- acc_idle_i  in  1  accessor idle_o
- acc_done_i  in  1  accessor done_o
- acc_start_o  out  1  to accessor start_run_i; one-cycle pulse
- acc_count_o  out  CNT_BIT  to accessor run_count_i; valid only while acc_start_o=1, else 0
- acc_base_o  out  AWIDTH  base offset of the job in flight; held LAUNCH through DONE, else 0
- busy_o  out  1  state ≠ IDLE
- job_done_o  out  1  one-cycle pulse per completed job
- done_cnt_o  out  DONE_CW  completed jobs since reset; wraps
- err_ovf_o  out  1  sticky: push while full
- err_zero_o  out  1  sticky: push with count 0

## Operation
- Job FIFO: QDEPTH entries of {count, base}. Write and read pointers are QAW bits and wrap modulo QDEPTH. level_o, full_o and empty_o are registered and updated on the same edge as the push or pop.
- Push acceptance requires push_i=1, full_o=0, push_count_i≠0 and flush_i=0.
  - Push with full_o=1 is dropped and sets err_ovf_o. This holds even if a pop happens on the same edge.
  - Push with count 0 is dropped and sets err_zero_o.
  - Push with flush_i=1 is dropped silently.
- Flush: level goes to 0, pointers go to 0, both error flags clear. FSM state and the in-flight job are unaffected.
- FSM states are IDLE, LAUNCH, WAIT and DONE.
  - IDLE: if empty_o=0 and acc_idle_i=1 and flush_i=0, pop the head into the launch registers and go to LAUNCH. Otherwise stay.
  - LAUNCH: acc_start_o=1, acc_count_o=job count. Go to WAIT unconditionally.
  - WAIT: on acc_done_i=1 go to DONE. Otherwise stay; there is no timeout.
  - DONE: job_done_o=1, done_cnt_o increments (wraps at 2^DONE_CW). Go to IDLE.
- acc_done_i outside WAIT is ignored.
- Push and pop on the same edge: level is unchanged, and both entries are handled correctly.
- Outputs acc_start_o, acc_count_o, acc_base_o, job_done_o and busy_o are decoded from registered state and launch registers only. There are no combinational paths from the inputs.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, pointers 0, level_o=0, empty_o=1, full_o=0. All other outputs are 0: acc_start_o, acc_count_o, acc_base_o, busy_o, job_done_o, done_cnt_o, err_ovf_o, err_zero_o.
- Reset mid-job abandons the job with no done pulse. The accessor shares reset_n.
- Push sampled at edge E0 into an empty queue with an idle accessor:
  - level_o=1 after E0.
  - Pop at E1, state becomes LAUNCH.
  - acc_start_o is high for exactly the cycle between E1 and E2.
- acc_done_i sampled high at edge Ek:
  - job_done_o is high between Ek and Ek+1.
  - done_cnt_o has incremented after Ek.
  - State is IDLE after Ek+1.
  - The next pop can occur at Ek+2 at the earliest.
- Back-to-back queued jobs: gap from acc_done_i to the next acc_start_o is 3 cycles, provided acc_idle_i is already 1.
- A pop is delayed while acc_idle_i=0.

## Test plan
- Single job: push count=4, base=0x10 at E0 → acc_start_o high exactly one cycle after E1 with acc_count_o=4 and acc_base_o=0x10. Drive done 6 cycles later → job_done_o is a 1-cycle pulse, done_cnt_o=1, busy_o=0 two edges after done.
- Queue fill: push 5 jobs on consecutive cycles with the accessor held non-idle → level_o=4, full_o=1, err_ovf_o=1. Release, then complete 4 jobs → counts launched in push order, done_cnt_o=4, empty_o=1.
- Zero count and flush: push count=0 → dropped, err_zero_o=1, level_o=0. Push 3 jobs, then assert flush_i while one job is in WAIT → level_o=0, errors cleared, the in-flight job still completes, done_cnt_o=1.
- Simultaneous push/pop: with level_o=2, push on the same edge the IDLE pop occurs → level_o stays 2 and order is preserved. With full_o=1, push on the pop edge → dropped and err_ovf_o=1.
- Spurious/reset: acc_done_i pulse while IDLE → no job_done_o and no count change. Assert reset_n=0 during WAIT → all outputs return to their reset values asynchronously. After release, a new push runs normally.
- Wrap: run 2^DONE_CW+1 jobs with QDEPTH wrap many times (reduced DONE_CW=4) → done_cnt_o=1 and the pointers wrap with no lost or duplicated jobs.
